// File: rtl/redun_mont_ctrl.sv
// ---------------------------------------------------------------------------
// redun_mont_ctrl
// Job controller for an iterated modular-squaring core that works on
// redundant-form operands. A job supplies a start residue and an iteration
// count. The controller pulses the core once. It then captures each core
// result and feeds it back as the next operand. It stops on completion, on
// core overflow, or when the core goes silent for TIMEOUT cycles.
//
// Ports
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_start_val / o_start_rdy    job request handshake (ready only in IDLE)
//   i_start_sq, i_t              start residue, number of squarings
//   i_abort                      cancel the current job (wins over a start)
//   o_sq, o_sq_val               operand to the core, one-cycle start pulse
//   i_mul, i_mul_val, i_overflow core result, strobe, sticky overflow
//   o_res, o_res_val, i_res_rdy  final residue and result handshake
//   o_err                        0 ok, 1 overflow, 2 timeout
//   o_iter                       squarings completed in this job
// ---------------------------------------------------------------------------
module redun_mont_ctrl #(
    parameter int NUM_WRDS = 65,
    parameter int WRD_BITS = 16,
    parameter int CNT_BITS = 40,
    parameter int TIMEOUT  = 64
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_start_val,
    output logic                               o_start_rdy,
    input  logic [NUM_WRDS-1:0][WRD_BITS:0]    i_start_sq,
    input  logic [CNT_BITS-1:0]                i_t,
    input  logic                               i_abort,
    output logic [NUM_WRDS-1:0][WRD_BITS:0]    o_sq,
    output logic                               o_sq_val,
    input  logic [NUM_WRDS-1:0][WRD_BITS:0]    i_mul,
    input  logic                               i_mul_val,
    input  logic                               i_overflow,
    output logic [NUM_WRDS-1:0][WRD_BITS:0]    o_res,
    output logic                               o_res_val,
    input  logic                               i_res_rdy,
    output logic [1:0]                         o_err,
    output logic [CNT_BITS-1:0]                o_iter
);

    localparam int WD_BITS = $clog2(TIMEOUT + 1);

    typedef logic [NUM_WRDS-1:0][WRD_BITS:0] opnd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] ERR_OK  = 2'd0;
    localparam logic [1:0] ERR_OVF = 2'd1;
    localparam logic [1:0] ERR_TMO = 2'd2;

    state_t              state_q, state_d;
    opnd_t               sq_q, sq_d;
    opnd_t               res_q, res_d;
    logic [1:0]          err_q, err_d;
    logic [CNT_BITS-1:0] iter_q, iter_d;
    logic [CNT_BITS-1:0] tgt_q, tgt_d;
    logic [WD_BITS-1:0]  wdog_q, wdog_d;
    logic                sq_val_q, sq_val_d;
    logic                res_val_q, res_val_d;
    logic                start_rdy_q, start_rdy_d;

    logic                start_acc;
    logic                t_zero;
    logic [CNT_BITS-1:0] iter_inc;
    logic [WD_BITS-1:0]  wdog_inc;
    logic                wdog_expire;

    // A start is only taken when no abort is present in the same cycle.
    assign start_acc   = i_start_val && !i_abort;
    assign t_zero      = (i_t == {CNT_BITS{1'b0}});
    assign iter_inc    = iter_q + {{(CNT_BITS-1){1'b0}}, 1'b1};
    assign wdog_inc    = wdog_q + {{(WD_BITS-1){1'b0}}, 1'b1};
    assign wdog_expire = (wdog_inc == WD_BITS'(TIMEOUT));

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort leaves any busy state, overflow beats completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    state_d = t_zero ? ST_DONE : ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_d = i_abort ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                end else if (i_mul_val) begin
                    if (i_overflow || (iter_inc == tgt_q)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (wdog_expire) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (i_abort || i_res_rdy) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output and datapath next values; handshake flags follow the next state
    // so they are registered yet line up with the state they describe.
    always_comb begin
        sq_d        = sq_q;
        res_d       = res_q;
        err_d       = err_q;
        iter_d      = iter_q;
        tgt_d       = tgt_q;
        wdog_d      = wdog_q;
        sq_val_d    = (state_d == ST_LOAD);
        res_val_d   = (state_d == ST_DONE);
        start_rdy_d = (state_d == ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    iter_d = {CNT_BITS{1'b0}};
                    wdog_d = {WD_BITS{1'b0}};
                    if (t_zero) begin
                        res_d = i_start_sq;
                        err_d = ERR_OK;
                    end else begin
                        sq_d  = i_start_sq;
                        tgt_d = i_t;
                    end
                end else begin
                    wdog_d = wdog_q;
                end
            end
            ST_LOAD: begin
                wdog_d = {WD_BITS{1'b0}};
            end
            ST_RUN: begin
                if (i_abort) begin
                    wdog_d = {WD_BITS{1'b0}};
                end else if (i_mul_val) begin
                    iter_d = iter_inc;
                    sq_d   = i_mul;
                    wdog_d = {WD_BITS{1'b0}};
                    if (i_overflow) begin
                        res_d = i_mul;
                        err_d = ERR_OVF;
                    end else if (iter_inc == tgt_q) begin
                        res_d = i_mul;
                        err_d = ERR_OK;
                    end else begin
                        err_d = err_q;
                    end
                end else if (wdog_expire) begin
                    wdog_d = wdog_inc;
                    res_d  = sq_q;
                    err_d  = ERR_TMO;
                end else begin
                    wdog_d = wdog_inc;
                end
            end
            ST_DONE: begin
                wdog_d = wdog_q;
            end
            default: begin
                wdog_d = {WD_BITS{1'b0}};
            end
        endcase
    end

    // Datapath and registered handshake outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sq_q        <= '0;
            res_q       <= '0;
            err_q       <= ERR_OK;
            iter_q      <= {CNT_BITS{1'b0}};
            tgt_q       <= {CNT_BITS{1'b0}};
            wdog_q      <= {WD_BITS{1'b0}};
            sq_val_q    <= 1'b0;
            res_val_q   <= 1'b0;
            start_rdy_q <= 1'b1;
        end else begin
            sq_q        <= sq_d;
            res_q       <= res_d;
            err_q       <= err_d;
            iter_q      <= iter_d;
            tgt_q       <= tgt_d;
            wdog_q      <= wdog_d;
            sq_val_q    <= sq_val_d;
            res_val_q   <= res_val_d;
            start_rdy_q <= start_rdy_d;
        end
    end

    assign o_start_rdy = start_rdy_q;
    assign o_sq        = sq_q;
    assign o_sq_val    = sq_val_q;
    assign o_res       = res_q;
    assign o_res_val   = res_val_q;
    assign o_err       = err_q;
    assign o_iter      = iter_q;

endmodule

// File: tb/tb_redun_mont_ctrl.sv
// ---------------------------------------------------------------------------
// tb_redun_mont_ctrl
// Self-checking bench: a behavioural squaring core (x*x mod N every 7 cycles)
// drives the controller; a job-level arithmetic model predicts the final
// residue, error code, iteration count and latency of each job.
// ---------------------------------------------------------------------------
module tb_redun_mont_ctrl;

    localparam int NUM_WRDS = 65;
    localparam int WRD_BITS = 16;
    localparam int CNT_BITS = 40;
    localparam int TIMEOUT  = 64;
    localparam int CORE_LAT = 7;

    typedef logic [NUM_WRDS-1:0][WRD_BITS:0] opnd_t;

    logic                i_clk = 1'b0;
    logic                i_rst;
    logic                i_start_val;
    logic                o_start_rdy;
    opnd_t               i_start_sq;
    logic [CNT_BITS-1:0] i_t;
    logic                i_abort;
    opnd_t               o_sq;
    logic                o_sq_val;
    opnd_t               i_mul;
    logic                i_mul_val;
    logic                i_overflow;
    opnd_t               o_res;
    logic                o_res_val;
    logic                i_res_rdy;
    logic [1:0]          o_err;
    logic [CNT_BITS-1:0] o_iter;

    int     n_total = 0;
    int     n_bad   = 0;

    // core model configuration (per job)
    longint cfg_n     = 1000003;
    int     cfg_ovf   = 0;
    int     cfg_stall = -1;

    redun_mont_ctrl #(
        .NUM_WRDS (NUM_WRDS),
        .WRD_BITS (WRD_BITS),
        .CNT_BITS (CNT_BITS),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start_val (i_start_val),
        .o_start_rdy (o_start_rdy),
        .i_start_sq  (i_start_sq),
        .i_t         (i_t),
        .i_abort     (i_abort),
        .o_sq        (o_sq),
        .o_sq_val    (o_sq_val),
        .i_mul       (i_mul),
        .i_mul_val   (i_mul_val),
        .i_overflow  (i_overflow),
        .o_res       (o_res),
        .o_res_val   (o_res_val),
        .i_res_rdy   (i_res_rdy),
        .o_err       (o_err),
        .o_iter      (o_iter)
    );

    always #5 i_clk = ~i_clk;

    function automatic opnd_t pack(input longint v);
        opnd_t r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i] = {1'b0, 16'(v >> (16 * i))};
        end
        return r;
    endfunction

    function automatic longint to_val(input opnd_t r);
        longint s;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            s = s + (longint'(r[i]) << (16 * i));
        end
        return s;
    endfunction

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Job-level reference: walk the squarings with plain arithmetic.
    task automatic job_model(input longint x, input longint n, input int t,
                             input int ovf, input int stall,
                             output longint e_res, output int e_err,
                             output int e_iter, output int e_lat);
        longint v;
        bit     fin;
        int     k;
        v = x; fin = 1'b0; k = 0;
        e_res = x; e_err = 0; e_iter = 0; e_lat = 0;
        if (t != 0) begin
            while (!fin) begin
                k++;
                if (stall >= 0 && k > stall) begin
                    e_res = v; e_err = 2; e_iter = stall;
                    e_lat = CORE_LAT * stall + 1 + TIMEOUT; fin = 1'b1;
                end else begin
                    v = (v * v) % n;
                    if (ovf != 0 && k >= ovf) begin
                        e_res = v; e_err = 1; e_iter = k; e_lat = CORE_LAT * k + 1; fin = 1'b1;
                    end else if (k == t) begin
                        e_res = v; e_err = 0; e_iter = k; e_lat = CORE_LAT * k + 1; fin = 1'b1;
                    end
                end
            end
        end
    endtask

    // Behavioural squaring core: result every CORE_LAT cycles after a pulse.
    initial begin : core_model
        bit     core_on;
        int     core_cnt;
        int     core_idx;
        core_on = 1'b0; core_cnt = 0; core_idx = 0;
        i_mul_val = 1'b0; i_mul = '0; i_overflow = 1'b0;
        forever begin
            @(posedge i_clk); #1;
            i_mul_val = 1'b0;
            if (i_rst) begin
                core_on = 1'b0;
            end else if (o_sq_val) begin
                core_on = 1'b1; core_cnt = 0; core_idx = 0; i_overflow = 1'b0;
            end else if (core_on) begin
                core_cnt++;
                if (core_cnt == CORE_LAT) begin
                    core_cnt = 0;
                    if (cfg_stall < 0 || core_idx < cfg_stall) begin
                        core_idx++;
                        i_mul     = pack((to_val(o_sq) * to_val(o_sq)) % cfg_n);
                        i_mul_val = 1'b1;
                        if (cfg_ovf != 0 && core_idx >= cfg_ovf) i_overflow = 1'b1;
                    end
                end
            end
        end
    end

    task automatic run_job(input longint x, input longint n, input int t,
                           input int ovf, input int stall, input bit hold);
        longint e_res;
        int     e_err, e_iter, e_lat;
        int     lat, pulses, first_p;
        longint prev_iter;
        bit     moved;
        longint h_res, h_err, h_iter;
        job_model(x, n, t, ovf, stall, e_res, e_err, e_iter, e_lat);
        cfg_n = n; cfg_ovf = ovf; cfg_stall = stall;
        check_val("idle_rdy", longint'(o_start_rdy), 1);
        i_start_sq  = pack(x);
        i_t         = CNT_BITS'(t);
        i_start_val = 1'b1;
        @(posedge i_clk); #1;
        i_start_val = 1'b0;
        lat = -1; pulses = 0; first_p = -1; prev_iter = 0;
        for (int k = 0; k < 3000; k++) begin
            if (k > 0) begin
                @(posedge i_clk); #1;
            end
            if (o_sq_val) begin
                pulses++;
                if (first_p < 0) first_p = k;
            end
            if (longint'(o_iter) != prev_iter) begin
                check_val("iter_step", longint'(o_iter), prev_iter + 1);
                prev_iter = longint'(o_iter);
            end
            if (o_res_val) begin
                lat = k;
                break;
            end
        end
        check_val("latency", lat, e_lat);
        check_val("res", to_val(o_res), e_res);
        check_val("err", longint'(o_err), e_err);
        check_val("iter", longint'(o_iter), e_iter);
        check_val("pulses", pulses, (t != 0) ? 1 : 0);
        if (t != 0) check_val("pulse_pos", first_p, 0);
        if (hold) begin
            h_res = to_val(o_res); h_err = longint'(o_err); h_iter = longint'(o_iter);
            moved = 1'b0;
            i_start_sq = pack(11); i_t = CNT_BITS'(1); i_start_val = 1'b1;
            for (int k = 0; k < 20; k++) begin
                @(posedge i_clk); #1;
                if (to_val(o_res) != h_res || longint'(o_err) != h_err ||
                    longint'(o_iter) != h_iter || !o_res_val || o_start_rdy || o_sq_val)
                    moved = 1'b1;
            end
            i_start_val = 1'b0;
            check_val("hold_stable", longint'(moved), 0);
        end
        i_res_rdy = 1'b1;
        @(posedge i_clk); #1;
        i_res_rdy = 1'b0;
        check_val("back_idle_val", longint'(o_res_val), 0);
        check_val("back_idle_rdy", longint'(o_start_rdy), 1);
    endtask

    task automatic start_long_job(input longint x, input int t);
        cfg_n = 1000003; cfg_ovf = 0; cfg_stall = -1;
        i_start_sq = pack(x); i_t = CNT_BITS'(t); i_start_val = 1'b1;
        @(posedge i_clk); #1;
        i_start_val = 1'b0;
    endtask

    initial begin : main
        longint n, x;
        int     t, mode, ovf, stall, waited;
        bit     seen;
        i_rst = 1'b1; i_start_val = 1'b0; i_start_sq = '0; i_t = '0;
        i_abort = 1'b0; i_res_rdy = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check_val("rst_state_rdy", longint'(o_start_rdy), 1);
        check_val("rst_res_val", longint'(o_res_val), 0);
        check_val("rst_sq_val", longint'(o_sq_val), 0);
        check_val("rst_iter", longint'(o_iter), 0);
        check_val("rst_res", longint'(o_res != '0), 0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        run_job(3, 1000003, 3, 0, -1, 1'b0);
        run_job(5, 1000003, 0, 0, -1, 1'b0);
        run_job(12345, 1000003, 10, 4, -1, 1'b0);
        run_job(777, 1000003, 5, 0, 2, 1'b0);
        run_job(7, 1000003, 4, 0, -1, 1'b1);

        // abort while running: back to IDLE, no result afterwards
        start_long_job(13, 10);
        repeat (10) @(posedge i_clk);
        #1;
        i_abort = 1'b1;
        @(posedge i_clk); #1;
        i_abort = 1'b0;
        check_val("abort_rdy", longint'(o_start_rdy), 1);
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge i_clk); #1;
            if (o_res_val || o_sq_val) seen = 1'b1;
        end
        check_val("abort_quiet", longint'(seen), 0);

        // abort together with a start: start not taken
        i_start_sq = pack(9); i_t = CNT_BITS'(2); i_start_val = 1'b1; i_abort = 1'b1;
        @(posedge i_clk); #1;
        i_start_val = 1'b0; i_abort = 1'b0;
        check_val("abort_start_rdy", longint'(o_start_rdy), 1);
        check_val("abort_start_pulse", longint'(o_sq_val), 0);

        // reset in the middle of a job
        start_long_job(3, 10);
        waited = 0;
        while (o_iter != CNT_BITS'(2) && waited < 200) begin
            @(posedge i_clk); #1;
            waited++;
        end
        check_val("reach_iter2", longint'(o_iter), 2);
        i_rst = 1'b1;
        #1;
        check_val("mrst_rdy", longint'(o_start_rdy), 1);
        check_val("mrst_res_val", longint'(o_res_val), 0);
        check_val("mrst_sq_val", longint'(o_sq_val), 0);
        check_val("mrst_err", longint'(o_err), 0);
        check_val("mrst_iter", longint'(o_iter), 0);
        check_val("mrst_res", longint'(o_res != '0), 0);
        check_val("mrst_sq", longint'(o_sq != '0), 0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        run_job(3, 1000003, 1, 0, -1, 1'b0);

        // randomized jobs
        for (int j = 0; j < 10; j++) begin
            n = longint'($urandom_range(1000, 1000003));
            x = longint'($urandom_range(2, 999));
            t = int'($urandom_range(0, 6));
            mode = int'($urandom_range(0, 2));
            ovf = 0; stall = -1;
            if (t != 0 && mode == 1) ovf = int'($urandom_range(1, t));
            if (t != 0 && mode == 2) stall = int'($urandom_range(0, t - 1));
            run_job(x, n, t, ovf, stall, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
